// File: rtl/comparator_array.sv
// Multi-channel clocked comparator with hysteresis and consecutive-sample debounce.
// Optional per-channel rising-edge event counters when COMPARATOR_ARRAY_EVENT_CNT_EN is defined.
module comparator_array #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned HYST     = 0,
  parameter int unsigned DEBOUNCE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CH*WIDTH-1:0] in_p,
  input  logic [N_CH*WIDTH-1:0] in_n,
  output logic [N_CH-1:0]       out,
  output logic [N_CH-1:0]       toggle,
  output logic                  out_valid
`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
  ,
  output logic [N_CH*8-1:0]     rise_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic signed [WIDTH:0] HYST_S = (WIDTH+1)'(HYST);

  logic [N_CH-1:0]         out_q, out_d;
  logic [N_CH-1:0]         toggle_q, toggle_d;
  logic                    valid_q, valid_d;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0][CW-1:0] cnt_inc;
  logic [N_CH-1:0]         raw;

  // Per-channel difference (WIDTH+1 bits, cannot overflow) and hysteretic raw decision
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic signed [WIDTH:0] p_ext;
    logic signed [WIDTH:0] n_ext;
    logic signed [WIDTH:0] diff;
    assign p_ext      = {in_p[g*WIDTH+WIDTH-1], in_p[g*WIDTH +: WIDTH]};
    assign n_ext      = {in_n[g*WIDTH+WIDTH-1], in_n[g*WIDTH +: WIDTH]};
    assign diff       = p_ext - n_ext;
    assign raw[g]     = out_q[g] ? !(diff < -HYST_S) : (diff > HYST_S);
    assign cnt_inc[g] = cnt_q[g] + CW'(1);
  end

  always_comb begin
    out_d    = out_q;
    toggle_d = '0;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    if (en) begin
      valid_d = 1'b1;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (raw[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_inc[i] == CW'(DEBOUNCE)) begin
          out_d[i]    = ~out_q[i];
          toggle_d[i] = 1'b1;
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_inc[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      toggle_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      toggle_q <= toggle_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out       = out_q;
  assign toggle    = toggle_q;
  assign out_valid = valid_q;

`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
  logic [N_CH-1:0][7:0] rise_q, rise_d;

  // Saturating count of 0->1 transitions of out
  always_comb begin
    rise_d = rise_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (toggle_d[i] && out_d[i] && (rise_q[i] != 8'hFF)) begin
        rise_d[i] = rise_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
    end else begin
      rise_q <= rise_d;
    end
  end

  assign rise_cnt = rise_q;
`endif

endmodule

// File: tb/tb_comparator_array.sv
// Directed-vector bench for comparator_array: three instances cover the
// base 4-channel, hysteresis and debounce configurations.
module tb_comparator_array;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [63:0] p4, n4;
  logic [3:0]  o4, t4;
  logic        v4;
  logic [15:0] ph, nh;
  logic        oh, th, vh;
  logic [15:0] pd, nd;
  logic        od, td, vd;
`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
  logic [31:0] r4;
  logic [7:0]  rh, rd;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comparator_array #(.N_CH(4), .WIDTH(16), .HYST(0), .DEBOUNCE(1)) u_base (
    .clk(clk), .rst_n(rst_n), .en(en), .in_p(p4), .in_n(n4),
    .out(o4), .toggle(t4), .out_valid(v4)
`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
    , .rise_cnt(r4)
`endif
  );

  comparator_array #(.N_CH(1), .WIDTH(16), .HYST(10), .DEBOUNCE(1)) u_hyst (
    .clk(clk), .rst_n(rst_n), .en(en), .in_p(ph), .in_n(nh),
    .out(oh), .toggle(th), .out_valid(vh)
`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
    , .rise_cnt(rh)
`endif
  );

  comparator_array #(.N_CH(1), .WIDTH(16), .HYST(0), .DEBOUNCE(3)) u_deb (
    .clk(clk), .rst_n(rst_n), .en(en), .in_p(pd), .in_n(nd),
    .out(od), .toggle(td), .out_valid(vd)
`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
    , .rise_cnt(rd)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given strobe; outputs sampled 1 time unit later
  task automatic step(input logic en_v);
    en = en_v;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int ntog;
    int dseq [6];
    logic [5:0] dexp;
    int hseq [5];
    logic [4:0] hout;
    logic [4:0] htog;

    rst_n = 1'b0;
    en    = 1'b0;
    p4 = '0; n4 = '0; ph = '0; nh = '0; pd = '0; nd = '0;
    #3;
    check("rst_out4", 32'(o4), 32'd0);
    check("rst_tog4", 32'(t4), 32'd0);
    check("rst_valid", 32'({v4, vh, vd}), 32'd0);
    #9;
    rst_n = 1'b1;

    // Single-channel sweep on channel 0 against 345
    ntog = 0;
    n4[15:0] = 16'(345);
    for (int k = 0; k < 40; k++) begin
      p4[15:0] = 16'(k * 25);
      step(1'b1);
      check("sweep_out", 32'(o4[0]), 32'((k * 25) > 345));
      check("sweep_valid", 32'(v4), 32'd1);
      if (t4[0]) ntog++;
    end
    check("sweep_toggles", 32'(ntog), 32'd1);
    check("sweep_others", 32'(o4[3:1]), 32'd0);

    // Disabled edge holds out and clears strobes
    p4[15:0] = 16'(0);
    step(1'b0);
    check("hold_out", 32'(o4[0]), 32'd1);
    check("hold_valid", 32'(v4), 32'd0);
    check("hold_tog", 32'(t4), 32'd0);

    // Multi-channel extremes from reset
    pulse_reset();
    p4 = {16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
    n4 = {16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    step(1'b1);
    check("ext_out", 32'(o4), 32'b0010);
    check("ext_tog", 32'(t4), 32'b0010);
    p4 = {16'h1234, 16'h8000, 16'h8000, 16'h7FFF};
    n4 = {16'h1234, 16'h8000, 16'h7FFF, 16'h8000};
    step(1'b1);
    check("ext_rev_out", 32'(o4), 32'b0001);
    check("ext_rev_tog", 32'(t4), 32'b0011);
    step(1'b1);
    check("ext_tog_clear", 32'(t4), 32'd0);

    // Hysteresis band of 10 LSBs
    hseq = '{5, 11, 5, -10, -11};
    hout = 5'b01110;
    htog = 5'b10010;
    for (int k = 0; k < 5; k++) begin
      ph = 16'(hseq[k]);
      step(1'b1);
      check("hyst_out", 32'(oh), 32'(hout[k]));
      check("hyst_tog", 32'(th), 32'(htog[k]));
    end

    // Debounce of 3, plain then with disabled edges interleaved
    dseq = '{5, 5, -5, 5, 5, 5};
    dexp = 6'b100000;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_reset();
      for (int k = 0; k < 6; k++) begin
        pd = 16'(dseq[k]);
        step(1'b1);
        check("deb_out", 32'(od), 32'(dexp[k]));
        check("deb_tog", 32'(td), 32'(dexp[k]));
        if (pass == 1) begin
          pd = 16'(-dseq[k]);
          step(1'b0);
          check("deb_idle_out", 32'(od), 32'(dexp[k]));
          check("deb_idle_valid", 32'(vd), 32'd0);
        end
      end
    end

    // Reset mid-debounce: out=1 with count at 2 of 3
    pd = 16'(-5);
    step(1'b1);
    step(1'b1);
    check("mid_pre_out", 32'(od), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(od), 32'd0);
    check("mid_rst_tog", 32'(td), 32'd0);
    #1;
    rst_n = 1'b1;
    pd = 16'(5);
    step(1'b1);
    step(1'b1);
    check("post_rst_out", 32'(od), 32'd0);
    step(1'b1);
    check("post_rst_flip", 32'(od), 32'd1);

`ifdef COMPARATOR_ARRAY_EVENT_CNT_EN
    // 300 rising transitions on channel 0 saturate its counter
    pulse_reset();
    p4 = '0;
    n4 = '0;
    for (int k = 0; k < 300; k++) begin
      p4[15:0] = 16'(1);
      step(1'b1);
      p4[15:0] = 16'(-1);
      step(1'b1);
      if (k == 99) check("rise_100", 32'(r4[7:0]), 32'd100);
    end
    check("rise_sat", 32'(r4[7:0]), 32'd255);
    check("rise_others", 32'(r4[31:8]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
